// File: rtl/regfile_pkg.sv
// Shared register-file constants used by the register file and its write-side arbiter.
package regfile_pkg;

  localparam int REG_COUNT      = 32;
  localparam int REG_BUS_WIDTH  = 32;
  localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);
  localparam int ZERO_REG       = 0;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: round-robin from a stored pointer, or fixed priority with index 0 highest.
module rr_arbiter #(
  parameter int N          = 3,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int PTR_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] start;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W:0]   sum;
  logic             found;

  always_comb begin
    start   = FIXED_PRIO ? '0 : rr_ptr;
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    // Scan upward from the start point, wrapping past N-1 back to 0.
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    if (win_idx == PTR_W'(N - 1)) next_ptr = '0;
    else                          next_ptr = win_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance && !FIXED_PRIO) begin
      rr_ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among writeback sources; the winner is registered
// into a single output stage that drives the write port and the hazard-visible pending write.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int COUNT      = REG_COUNT,
  parameter int BUS_WIDTH  = REG_BUS_WIDTH,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int ADDR_WIDTH = $clog2(COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          freeze,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         write_addr,
  output logic [BUS_WIDTH-1:0]          data_in,
  output logic                          pend_valid,
  output logic [ADDR_WIDTH-1:0]         pend_addr
);

  logic [NUM_REQ-1:0]    req_gated;
  logic [NUM_REQ-1:0]    grant;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BUS_WIDTH-1:0]  sel_data;

  // Ready is forced low during reset so no requester sees a phantom acceptance.
  assign req_gated = (freeze || !rst_n) ? '0 : req_valid;

  rr_arbiter #(
    .N          (NUM_REQ),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_gated),
    .advance (transfer),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign transfer  = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // A write to the zero register is consumed here and never reaches the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      write_addr <= '0;
      data_in    <= '0;
    end else if (transfer) begin
      wr_en      <= (sel_addr != ADDR_WIDTH'(ZERO_REG));
      write_addr <= sel_addr;
      data_in    <= sel_data;
    end else begin
      wr_en      <= 1'b0;
    end
  end

  assign pend_valid = wr_en;
  assign pend_addr  = write_addr;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Checks round-robin and fixed-priority variants against a behavioural model, plus directed scenarios.
module tb_regfile_write_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic            freeze;

  logic [NR-1:0]   rr_ready, fx_ready;
  logic            rr_wr_en, fx_wr_en, rr_pv, fx_pv;
  logic [AW-1:0]   rr_waddr, fx_waddr, rr_pa, fx_pa;
  logic [DW-1:0]   rr_din, fx_din;

  regfile_write_arbiter #(.NUM_REQ(NR), .COUNT(32), .BUS_WIDTH(DW), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rr_ready), .freeze(freeze), .wr_en(rr_wr_en), .write_addr(rr_waddr),
    .data_in(rr_din), .pend_valid(rr_pv), .pend_addr(rr_pa));

  regfile_write_arbiter #(.NUM_REQ(NR), .COUNT(32), .BUS_WIDTH(DW), .FIXED_PRIO(1'b1)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(fx_ready), .freeze(freeze), .wr_en(fx_wr_en), .write_addr(fx_waddr),
    .data_in(fx_din), .pend_valid(fx_pv), .pend_addr(fx_pa));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register file fed by the round-robin instance's write port.
  logic [DW-1:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (rr_wr_en) rf[rr_waddr] <= rr_din;

  // Behavioural model
  int            m_ptr;
  logic          m_rr_wr, m_fx_wr;
  logic [AW-1:0] m_rr_addr, m_fx_addr;
  logic [DW-1:0] m_rr_data, m_fx_data;
  logic [NR-1:0] last_acc;

  function automatic int first_valid(input logic [NR-1:0] v, input int start);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (start + k) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready(input int start);
    int j;
    if (!rst_n || freeze) return '0;
    j = first_valid(req_valid, start);
    if (j < 0) return '0;
    return NR'(1) << j;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; last_acc = '0;
      m_rr_wr = 0; m_rr_addr = '0; m_rr_data = '0;
      m_fx_wr = 0; m_fx_addr = '0; m_fx_data = '0;
    end else begin
      int g;
      g = freeze ? -1 : first_valid(req_valid, m_ptr);
      last_acc = '0;
      if (g >= 0) begin
        last_acc[g] = 1'b1;
        m_rr_addr = req_addr[g*AW +: AW];
        m_rr_data = req_data[g*DW +: DW];
        m_rr_wr   = (m_rr_addr != 0);
        m_ptr     = (g + 1) % NR;
      end else m_rr_wr = 1'b0;
      g = freeze ? -1 : first_valid(req_valid, 0);
      if (g >= 0) begin
        m_fx_addr = req_addr[g*AW +: AW];
        m_fx_data = req_data[g*DW +: DW];
        m_fx_wr   = (m_fx_addr != 0);
      end else m_fx_wr = 1'b0;
    end
  end

  // Compare process, plus the round-robin fairness bound.
  int wait_cnt [NR];
  initial for (int i = 0; i < NR; i++) wait_cnt[i] = 0;

  always @(negedge clk) begin
    chk("rr_ready", rr_ready, exp_ready(m_ptr));
    chk("rr_wr_en", rr_wr_en, m_rr_wr);
    chk("rr_write_addr", rr_waddr, m_rr_addr);
    chk("rr_data_in", rr_din, m_rr_data);
    chk("rr_pend_valid", rr_pv, m_rr_wr);
    chk("rr_pend_addr", rr_pa, m_rr_addr);
    chk("fx_ready", fx_ready, exp_ready(0));
    chk("fx_wr_en", fx_wr_en, m_fx_wr);
    chk("fx_write_addr", fx_waddr, m_fx_addr);
    chk("fx_data_in", fx_din, m_fx_data);
    chk("fx_pend_valid", fx_pv, m_fx_wr);
    chk("fx_pend_addr", fx_pa, m_fx_addr);
    for (int i = 0; i < NR; i++) begin
      if (!rst_n || !req_valid[i]) wait_cnt[i] = 0;
      else if (!freeze) begin
        if (rr_ready[i]) begin
          chk("rr_fairness", (wait_cnt[i] < NR), 1'b1);
          wait_cnt[i] = 0;
        end else wait_cnt[i]++;
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst_n = 1'b0; freeze = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    set_req(0, 1'b1, 5'd5, 32'hA0);
    set_req(1, 1'b1, 5'd6, 32'hB1);
    set_req(2, 1'b1, 5'd7, 32'hC2);
    repeat (3) @(negedge clk);
    #2;
    chk("rst_wr_en", rr_wr_en, 1'b0);
    chk("rst_write_addr", rr_waddr, 5'd0);
    chk("rst_data_in", rr_din, 32'd0);
    chk("rst_pend_valid", rr_pv, 1'b0);
    chk("rst_ready", rr_ready, 3'b000);
    chk("rst_fx_ready", fx_ready, 3'b000);

    // Rotation 0,1,2,0 with commits one edge after acceptance
    @(negedge clk); #1 rst_n = 1'b1;
    #1 chk("first_grant", rr_ready, 3'b001);
    @(negedge clk); #2;
    chk("rot_ready1", rr_ready, 3'b010);
    chk("rot_wr_en", rr_wr_en, 1'b1);
    chk("rot_addr5", rr_waddr, 5'd5);
    chk("rot_dataA0", rr_din, 32'hA0);
    chk("fx_hold0", fx_ready, 3'b001);
    @(negedge clk); #2;
    chk("rot_ready2", rr_ready, 3'b100);
    chk("rot_addr6", rr_waddr, 5'd6);
    chk("rf_r5", rf[5], 32'hA0);
    @(negedge clk); #2;
    chk("rot_ready0", rr_ready, 3'b001);
    chk("rf_r6", rf[6], 32'hB1);
    @(negedge clk); #2;
    chk("rf_r7", rf[7], 32'hC2);

    // Register 0 write is accepted but never enables the port
    req_valid = '0;
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1 chk("r0_ready", rr_ready, 3'b010);
    @(negedge clk); #2;
    chk("r0_wr_en", rr_wr_en, 1'b0);
    chk("r0_read", rf[0], 32'd0);
    set_req(0, 1'b1, 5'd5, 32'hA0);
    set_req(1, 1'b1, 5'd6, 32'hB1);
    set_req(2, 1'b1, 5'd7, 32'hC2);
    #1 chk("r0_next_ptr", rr_ready, 3'b100);

    // Freeze two cycles, then resume at the saved pointer
    freeze = 1'b1;
    #1 chk("frz_ready_a", rr_ready, 3'b000);
    @(negedge clk); #2;
    chk("frz_ready_b", rr_ready, 3'b000);
    chk("frz_wr_en_a", rr_wr_en, 1'b0);
    @(negedge clk); #2;
    chk("frz_wr_en_b", rr_wr_en, 1'b0);
    freeze = 1'b0;
    #1 chk("frz_resume", rr_ready, 3'b100);
    @(negedge clk); #2;
    chk("frz_commit_addr", rr_waddr, 5'd7);

    // Same-register conflict, pointer at 0
    req_valid = '0;
    set_req(0, 1'b1, 5'd9, 32'h11);
    set_req(2, 1'b1, 5'd9, 32'h22);
    #1 chk("cfl_ready0", rr_ready, 3'b001);
    @(negedge clk); #2;
    chk("cfl_pend_v1", rr_pv, 1'b1);
    chk("cfl_pend_a1", rr_pa, 5'd9);
    chk("cfl_data1", rr_din, 32'h11);
    req_valid[0] = 1'b0;
    #1 chk("cfl_ready2", rr_ready, 3'b100);
    @(negedge clk); #2;
    chk("cfl_r9_first", rf[9], 32'h11);
    chk("cfl_pend_v2", rr_pv, 1'b1);
    chk("cfl_pend_a2", rr_pa, 5'd9);
    chk("cfl_data2", rr_din, 32'h22);
    req_valid = '0;
    @(negedge clk); #2;
    chk("cfl_r9_second", rf[9], 32'h22);
    chk("cfl_idle_wr_en", rr_wr_en, 1'b0);

    // Fixed priority: requester 1 starves until requester 0 drops
    set_req(0, 1'b1, 5'd3, 32'h33);
    set_req(1, 1'b1, 5'd4, 32'h44);
    for (int c = 0; c < 4; c++) begin
      #1 chk("fx_prio0", fx_ready, 3'b001);
      @(negedge clk); #1;
    end
    req_valid[0] = 1'b0;
    #1 chk("fx_prio1", fx_ready, 3'b010);
    @(negedge clk); #2;
    chk("fx_commit_addr", fx_waddr, 5'd4);
    chk("fx_commit_wr", fx_wr_en, 1'b1);

    // Randomized traffic with held requests and occasional mid-run reset
    req_valid = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
      end
      freeze = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || last_acc[i]) begin
          set_req(i, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                  32'($urandom));
        end
      end
    end
    @(negedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
